// File: rtl/pc_predict_unit.sv
// pc_predict_unit
//   Next-PC generator for the pipelined MIPS core. Owns the fetch PC register,
//   predicts the next fetch address in IF from a direct-mapped branch history
//   table (2-bit saturating counters) and a tagged branch target buffer, and
//   resolves branches and jumps in EX, redirecting fetch on a mispredict.
//
// Parameters
//   PC_W     : PC width (bits [1:0] always zero)
//   DEPTH    : BHT/BTB entries, power of two, >= 2
//   RESET_PC : PC value after reset
//
// Ports
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   stall_i          : hold the PC (IF stalled)
//   pc_o             : current fetch PC (registered)
//   pred_npc_o       : predicted next PC for pc_o (combinational)
//   pred_taken_o     : BTB hit with counter predicting taken
//   ex_valid_i       : valid instruction in EX
//   ex_opcode_i/funct: EX instruction decode fields
//   ex_alu_zero_i    : EX ALU zero flag
//   ex_pc_i          : PC of the EX instruction
//   ex_pred_npc_i    : prediction that travelled with the EX instruction
//   ex_target_i      : resolved branch/jump/JR target
//   flush_o          : mispredict, kill IF/ID (combinational)
//   PC_select_o      : 0 predicted, 1 branch correction, 2 jump correction, 3 hold

module pc_predict_unit #(
    parameter int unsigned     PC_W     = 32,
    parameter int unsigned     DEPTH    = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] pred_npc_o,
    output logic            pred_taken_o,
    input  logic            ex_valid_i,
    input  logic [5:0]      ex_opcode_i,
    input  logic [5:0]      ex_funct_i,
    input  logic            ex_alu_zero_i,
    input  logic [PC_W-1:0] ex_pc_i,
    input  logic [PC_W-1:0] ex_pred_npc_i,
    input  logic [PC_W-1:0] ex_target_i,
    output logic            flush_o,
    output logic [1:0]      PC_select_o
);

    localparam int unsigned IDX   = $clog2(DEPTH);
    localparam int unsigned TAG_W = PC_W - IDX - 2;

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    localparam logic [5:0] OpSpecial = 6'b000000;
    localparam logic [5:0] OpJ       = 6'b000010;
    localparam logic [5:0] OpJal     = 6'b000011;
    localparam logic [5:0] OpBeq     = 6'b000100;
    localparam logic [5:0] OpBne     = 6'b000101;
    localparam logic [5:0] OpBlez    = 6'b000110;
    localparam logic [5:0] OpBgtz    = 6'b000111;
    localparam logic [5:0] FnJr      = 6'b001000;

    typedef enum logic [1:0] {
        SelPred   = 2'd0,
        SelBranch = 2'd1,
        SelJump   = 2'd2,
        SelHold   = 2'd3
    } pc_sel_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [PC_W-1:0]  tgt_q [DEPTH];
    logic [1:0]       cnt_q [DEPTH];

    // ------------------------------------------------------------------
    // IF lookup
    // ------------------------------------------------------------------
    logic [IDX-1:0]   rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_hit;
    logic [PC_W-1:0]  pc_plus4;

    assign rd_idx   = pc_q[IDX+1:2];
    assign rd_tag   = pc_q[PC_W-1:IDX+2];
    assign rd_hit   = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign pc_plus4 = pc_q + PC_STEP;

    assign pred_taken_o = rd_hit && cnt_q[rd_idx][1];
    assign pred_npc_o   = pred_taken_o ? tgt_q[rd_idx] : pc_plus4;
    assign pc_o         = pc_q;

    // ------------------------------------------------------------------
    // EX decode and resolution
    // ------------------------------------------------------------------
    logic            is_branch, is_jump, is_jr;
    logic            br_taken;
    logic            redirect;
    logic [PC_W-1:0] act_npc;
    logic            mis;

    always_comb begin
        is_branch = 1'b0;
        is_jump   = 1'b0;
        is_jr     = 1'b0;
        br_taken  = 1'b0;
        unique case (ex_opcode_i)
            OpBeq: begin
                is_branch = 1'b1;
                br_taken  = ex_alu_zero_i;
            end
            OpBne, OpBlez, OpBgtz: begin
                is_branch = 1'b1;
                br_taken  = !ex_alu_zero_i;
            end
            OpJ, OpJal: is_jump = 1'b1;
            OpSpecial:  is_jr   = (ex_funct_i == FnJr);
            default: ;
        endcase
    end

    assign redirect = (is_branch && br_taken) || is_jump || is_jr;
    assign act_npc  = redirect ? ex_target_i : (ex_pc_i + PC_STEP);

    // Reset also squashes a redirect that is still being presented in EX.
    assign mis = ex_valid_i && (act_npc != ex_pred_npc_i) && !rst_i;

    // ------------------------------------------------------------------
    // Next PC and select
    // ------------------------------------------------------------------
    always_comb begin
        pc_d        = pred_npc_o;
        PC_select_o = SelPred;
        if (mis) begin
            pc_d = act_npc;
            // A stale BTB hit on a non-control instruction is corrected like a
            // not-taken branch.
            PC_select_o = (is_jump || is_jr) ? SelJump : SelBranch;
        end else if (stall_i) begin
            pc_d        = pc_q;
            PC_select_o = SelHold;
        end
    end

    assign flush_o = mis;

    // ------------------------------------------------------------------
    // Table update (indexed from the EX PC, independent of stall)
    // ------------------------------------------------------------------
    logic [IDX-1:0]   wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_hit;
    logic             br_upd, jmp_upd;
    logic [1:0]       cnt_old, cnt_new;

    assign wr_idx  = ex_pc_i[IDX+1:2];
    assign wr_tag  = ex_pc_i[PC_W-1:IDX+2];
    assign wr_hit  = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    assign br_upd  = ex_valid_i && is_branch;
    assign jmp_upd = ex_valid_i && is_jump;
    assign cnt_old = cnt_q[wr_idx];

    always_comb begin
        cnt_new = cnt_old;
        if (br_taken) begin
            if (!wr_hit) begin
                cnt_new = 2'd2;          // fresh allocation starts weakly taken
            end else if (cnt_old != 2'd3) begin
                cnt_new = cnt_old + 2'd1;
            end
        end else if (cnt_old != 2'd0) begin
            // Not-taken decrements even on a tag miss; no entry is allocated.
            cnt_new = cnt_old - 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q    <= RESET_PC;
            valid_q <= '0;
            tag_q   <= '{default: '0};
            tgt_q   <= '{default: '0};
            cnt_q   <= '{default: 2'd1};
        end else begin
            pc_q <= pc_d;
            if (br_upd) begin
                cnt_q[wr_idx] <= cnt_new;
                if (br_taken) begin
                    // Covers both retargeting a hit and evicting on a miss.
                    valid_q[wr_idx] <= 1'b1;
                    tag_q[wr_idx]   <= wr_tag;
                    tgt_q[wr_idx]   <= ex_target_i;
                end
            end else if (jmp_upd) begin
                valid_q[wr_idx] <= 1'b1;
                tag_q[wr_idx]   <= wr_tag;
                tgt_q[wr_idx]   <= ex_target_i;
                cnt_q[wr_idx]   <= 2'd3;
            end
        end
    end

endmodule

// File: tb/tb_pc_predict_unit.sv
module tb_pc_predict_unit;

    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] RT  = 6'h00;
    localparam logic [5:0] BEQ = 6'h04;
    localparam logic [5:0] BNE = 6'h05;
    localparam logic [5:0] J   = 6'h02;
    localparam logic [5:0] JRF = 6'h08;

    logic        clk, rst, stall;
    logic [31:0] pc, pred_npc;
    logic        pred_taken;
    logic        ex_valid;
    logic [5:0]  ex_op, ex_fn;
    logic        ex_zero;
    logic [31:0] ex_pc, ex_pred, ex_tgt;
    logic        flush;
    logic [1:0]  sel;

    int checks = 0;
    int errors = 0;

    pc_predict_unit #(
        .PC_W(32), .DEPTH(16), .RESET_PC(32'h0)
    ) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall),
        .pc_o(pc), .pred_npc_o(pred_npc), .pred_taken_o(pred_taken),
        .ex_valid_i(ex_valid), .ex_opcode_i(ex_op), .ex_funct_i(ex_fn),
        .ex_alu_zero_i(ex_zero), .ex_pc_i(ex_pc), .ex_pred_npc_i(ex_pred),
        .ex_target_i(ex_tgt), .flush_o(flush), .PC_select_o(sel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        stall;
        logic        valid;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        zero;
        logic [31:0] epc;
        logic [31:0] epred;
        logic [31:0] etgt;
        logic [31:0] cur;
        logic [31:0] pred;
        logic        pt;
        logic        fl;
        logic [1:0]  sel;
        logic [31:0] nxt;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] exp_q[$];

    function automatic vec_t mk(logic st, logic va, logic [5:0] op, logic [5:0] fn, logic z,
                                logic [31:0] epc, logic [31:0] epred, logic [31:0] etgt,
                                logic [31:0] cur, logic [31:0] pred, logic pt, logic fl,
                                logic [1:0] s, logic [31:0] nxt);
        vec_t v;
        v.stall = st; v.valid = va; v.op = op; v.fn = fn; v.zero = z;
        v.epc = epc; v.epred = epred; v.etgt = etgt;
        v.cur = cur; v.pred = pred; v.pt = pt; v.fl = fl; v.sel = s; v.nxt = nxt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic va, input logic [5:0] op,
                         input logic [5:0] fn, input logic z, input logic [31:0] epc,
                         input logic [31:0] epred, input logic [31:0] etgt);
        stall = st; ex_valid = va; ex_op = op; ex_fn = fn; ex_zero = z;
        ex_pc = epc; ex_pred = epred; ex_tgt = etgt;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, LW, 6'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        // stall vld op  fn   z  ex_pc  ex_pred ex_tgt  | pc  pred  pt fl sel next
        tbl.push_back(mk(0, 0, LW,  0,   0, 0,     0,     0,     32'h00, 32'h04, 0, 0, 0, 32'h04));
        tbl.push_back(mk(0, 0, LW,  0,   0, 0,     0,     0,     32'h04, 32'h08, 0, 0, 0, 32'h08));
        tbl.push_back(mk(0, 0, LW,  0,   0, 0,     0,     0,     32'h08, 32'h0C, 0, 0, 0, 32'h0C));
        tbl.push_back(mk(1, 0, LW,  0,   0, 0,     0,     0,     32'h0C, 32'h10, 0, 0, 3, 32'h0C));
        tbl.push_back(mk(1, 0, LW,  0,   0, 0,     0,     0,     32'h0C, 32'h10, 0, 0, 3, 32'h0C));
        // cold taken BEQ at 0x10 -> 0x40
        tbl.push_back(mk(0, 1, BEQ, 0,   1, 'h10,  'h14,  'h40,  32'h0C, 32'h10, 0, 1, 1, 32'h40));
        tbl.push_back(mk(0, 0, LW,  0,   0, 0,     0,     0,     32'h40, 32'h44, 0, 0, 0, 32'h44));
        // J at 0x44 updates the entry being looked up: lookup still sees the old miss
        tbl.push_back(mk(0, 1, J,   0,   0, 'h44,  'h48,  'h10,  32'h44, 32'h48, 0, 1, 2, 32'h10));
        tbl.push_back(mk(0, 0, LW,  0,   0, 0,     0,     0,     32'h10, 32'h40, 1, 0, 0, 32'h40));
        // trained BNE at 0x10 now not taken
        tbl.push_back(mk(0, 1, BNE, 0,   1, 'h10,  'h40,  'h40,  32'h40, 32'h44, 0, 1, 1, 32'h14));
        tbl.push_back(mk(0, 0, LW,  0,   0, 0,     0,     0,     32'h14, 32'h18, 0, 0, 0, 32'h18));
        // JR at 0x20 -> 0x200
        tbl.push_back(mk(0, 1, RT,  JRF, 0, 'h20,  'h24,  'h200, 32'h18, 32'h1C, 0, 1, 2, 32'h200));
        tbl.push_back(mk(0, 0, LW,  0,   0, 0,     0,     0,     32'h200, 32'h204, 0, 0, 0, 32'h204));
        // JR mispredict while stalled: redirect wins
        tbl.push_back(mk(1, 1, RT,  JRF, 0, 'h30,  'h34,  'h10,  32'h204, 32'h208, 0, 1, 2, 32'h10));
        tbl.push_back(mk(0, 0, LW,  0,   0, 0,     0,     0,     32'h10, 32'h14, 0, 0, 0, 32'h14));
        tbl.push_back(mk(0, 1, J,   0,   0, 'h60,  'h64,  'h20,  32'h14, 32'h18, 0, 1, 2, 32'h20));
        // 0x20 aliases 0x60's entry but tag differs; JR never allocated it
        tbl.push_back(mk(0, 0, LW,  0,   0, 0,     0,     0,     32'h20, 32'h24, 0, 0, 0, 32'h24));
        // taken BEQ at 0x50 evicts the 0x10 entry
        tbl.push_back(mk(0, 1, BEQ, 0,   1, 'h50,  'h54,  'h80,  32'h24, 32'h28, 0, 1, 1, 32'h80));
        tbl.push_back(mk(0, 1, RT,  JRF, 0, 'h70,  'h74,  'h10,  32'h80, 32'h84, 0, 1, 2, 32'h10));
        tbl.push_back(mk(0, 0, LW,  0,   0, 0,     0,     0,     32'h10, 32'h14, 0, 0, 0, 32'h14));
        tbl.push_back(mk(0, 1, RT,  JRF, 0, 'h70,  'h74,  'h44,  32'h14, 32'h18, 0, 1, 2, 32'h44));
        tbl.push_back(mk(0, 0, LW,  0,   0, 0,     0,     0,     32'h44, 32'h10, 1, 0, 0, 32'h10));
        // correctly predicted branch: no flush
        tbl.push_back(mk(0, 1, BEQ, 0,   1, 'h50,  'h80,  'h80,  32'h10, 32'h14, 0, 0, 0, 32'h14));
        // invalid EX slot with mismatching fields is ignored
        tbl.push_back(mk(0, 0, BEQ, 0,   1, 'h10,  'h100, 'h40,  32'h14, 32'h18, 0, 0, 0, 32'h18));
        tbl.push_back(mk(0, 1, RT,  JRF, 0, 'h70,  'h74,  32'hFFFF_FFFC, 32'h18, 32'h1C, 0, 1, 2,
                         32'hFFFF_FFFC));
        // PC wrap
        tbl.push_back(mk(0, 0, LW,  0,   0, 0,     0,     0,     32'hFFFF_FFFC, 32'h0, 0, 0, 0,
                         32'h0));

        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #3;
        chk("reset pc", pc, 32'h0);
        chk("reset pred_npc", pred_npc, 32'h4);
        chk("reset pred_taken", {31'b0, pred_taken}, 32'h0);
        chk("reset flush", {31'b0, flush}, 32'h0);
        chk("reset sel", {30'b0, sel}, 32'h0);
        @(posedge clk);
        #1;
        // The cycle above advanced pc to 4; step once more with wrap back is not
        // wanted, so restart from a clean reset aligned to the table.
        rst = 1'b1;
        #1 rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].stall, tbl[i].valid, tbl[i].op, tbl[i].fn, tbl[i].zero,
                  tbl[i].epc, tbl[i].epred, tbl[i].etgt);
            #3;
            chk($sformatf("v%0d pc", i), pc, tbl[i].cur);
            chk($sformatf("v%0d pred_npc", i), pred_npc, tbl[i].pred);
            chk($sformatf("v%0d pred_taken", i), {31'b0, pred_taken}, {31'b0, tbl[i].pt});
            chk($sformatf("v%0d flush", i), {31'b0, flush}, {31'b0, tbl[i].fl});
            chk($sformatf("v%0d sel", i), {30'b0, sel}, {30'b0, tbl[i].sel});
            exp_q.push_back(tbl[i].nxt);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d next_pc", i), pc, exp_q.pop_front());
        end

        // Mid-run reset with a redirect pending in EX.
        idle();
        @(posedge clk);
        #1;
        chk("pre-reset pc", pc, 32'h4);
        drive(1'b0, 1'b1, RT, JRF, 1'b0, 32'h70, 32'h74, 32'h300);
        #1;
        chk("pre-reset flush", {31'b0, flush}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("async reset pc", pc, 32'h0);
        chk("async reset pred_npc", pred_npc, 32'h4);
        chk("async reset pred_taken", {31'b0, pred_taken}, 32'h0);
        chk("async reset flush", {31'b0, flush}, 32'h0);
        chk("async reset sel", {30'b0, sel}, 32'h0);
        @(posedge clk);
        #1;
        chk("reset drops redirect", pc, 32'h0);
        idle();
        rst = 1'b0;

        // Tables cleared by reset: the J entry at 0x44 must be gone.
        drive(1'b0, 1'b1, RT, JRF, 1'b0, 32'h70, 32'h74, 32'h44);
        @(posedge clk);
        #1;
        idle();
        #2;
        chk("post-reset pc", pc, 32'h44);
        chk("post-reset pred_taken", {31'b0, pred_taken}, 32'h0);
        chk("post-reset pred_npc", pred_npc, 32'h48);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
